// File: rtl/ifetch.sv
// ifetch: Wishbone instruction fetch unit with a small PC-tagged instruction
// buffer feeding decode over a valid/ready handshake.
// Optional feature: define IFETCH_TIMEOUT_EN to build a bus watchdog that
// turns a request left unanswered for TIMEOUT cycles into a fault entry.
module ifetch #(
  parameter int                   ADR_WIDTH = 16,
  parameter int                   DAT_WIDTH = 64,
  parameter logic [ADR_WIDTH-1:0] RESET_PC  = 16'h0000,
  parameter int                   DEPTH     = 2,
  parameter int                   TIMEOUT   = 255
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  output logic [ADR_WIDTH-1:0] ifu_adr_o,
  input  logic [DAT_WIDTH-1:0] ifu_dat_i,
  output logic [DAT_WIDTH-1:0] ifu_dat_o,
  output logic                 ifu_we_o,
  output logic                 ifu_cyc_o,
  output logic                 ifu_stb_o,
  input  logic                 ifu_ack_i,
  input  logic                 ifu_err_i,
  input  logic                 redirect_i,
  input  logic [ADR_WIDTH-1:0] redirect_pc_i,
  output logic                 valid_o,
  input  logic                 ready_i,
  output logic [DAT_WIDTH-1:0] instr_o,
  output logic [ADR_WIDTH-1:0] pc_o,
  output logic                 fault_o
);

  localparam int CW = $clog2(DEPTH) + 1;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_GAP} state_t;

  typedef struct packed {
    logic                 fault;
    logic [ADR_WIDTH-1:0] pc;
    logic [DAT_WIDTH-1:0] instr;
  } entry_t;

  state_t               state_reg, state_next;
  logic [ADR_WIDTH-1:0] fetch_pc_reg, fetch_pc_next;
  logic [ADR_WIDTH-1:0] adr_reg, adr_next;
  logic                 halted_reg, halted_next;
  logic                 stale_reg, stale_next;
  logic [CW-1:0]        count_reg, count_next;
  logic [CW-1:0]        wr_idx;
  entry_t               entry_reg [DEPTH];
  entry_t               push_entry;

  logic timeout_hit;
  logic bus_done;
  logic bus_fault;
  logic push;
  logic pop;

`ifdef IFETCH_TIMEOUT_EN
  localparam int TW = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;
  logic [TW-1:0] to_cnt_reg;

  // Cycles spent in the current REQ; restarts from 0 on every new request
  always_ff @(posedge clk_i) begin
    if (!rst_i || state_reg != S_REQ) to_cnt_reg <= '0;
    else                              to_cnt_reg <= to_cnt_reg + TW'(1);
  end

  // Fires on the TIMEOUT-th strobe cycle, so strobe is high for TIMEOUT cycles
  assign timeout_hit = (state_reg == S_REQ) && (to_cnt_reg == TW'(TIMEOUT - 1))
                       && !ifu_ack_i && !ifu_err_i;
`else
  assign timeout_hit = 1'b0;
`endif

  // A request ends on ack, err or watchdog; err/watchdog produce a fault entry.
  // Responses to a request overtaken by a redirect are dropped.
  assign bus_done  = (state_reg == S_REQ) && (ifu_ack_i || ifu_err_i || timeout_hit);
  assign bus_fault = ifu_err_i || timeout_hit;
  assign push      = bus_done && !stale_reg && !redirect_i;
  assign pop       = valid_o && ready_i && !redirect_i;
  assign wr_idx    = pop ? count_reg - CW'(1) : count_reg;

  // Entry built from the completing bus response
  always_comb begin
    push_entry.fault = bus_fault;
    push_entry.pc    = adr_reg;
    push_entry.instr = bus_fault ? '0 : ifu_dat_i;
  end

  // Bus FSM: next state, fetch PC, halt and stale tracking
  always_comb begin
    state_next    = state_reg;
    fetch_pc_next = fetch_pc_reg;
    adr_next      = adr_reg;
    halted_next   = halted_reg;
    stale_next    = stale_reg;
    case (state_reg)
      S_IDLE: begin
        // Nothing is in flight while idle, so occupancy alone gates a fetch
        if (!redirect_i && !halted_reg && count_reg < CW'(DEPTH)) begin
          state_next = S_REQ;
          adr_next   = fetch_pc_reg;
        end
      end
      S_REQ: begin
        if (bus_done) begin
          state_next = S_GAP;
          stale_next = 1'b0;
          if (push) begin
            if (bus_fault) halted_next   = 1'b1;
            else           fetch_pc_next = fetch_pc_reg + ADR_WIDTH'(8);
          end
        end else if (redirect_i) begin
          // Keep strobe up so the slave finishes cleanly; drop the reply later
          stale_next = 1'b1;
        end
      end
      S_GAP:   state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
    if (redirect_i) begin
      fetch_pc_next = redirect_pc_i & ~ADR_WIDTH'(7);
      halted_next   = 1'b0;
    end
  end

  // Buffer occupancy; a redirect empties the buffer
  always_comb begin
    count_next = count_reg;
    if (redirect_i)          count_next = '0;
    else if (push && !pop)   count_next = count_reg + CW'(1);
    else if (pop && !push)   count_next = count_reg - CW'(1);
  end

  // Control registers
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_reg    <= S_IDLE;
      fetch_pc_reg <= RESET_PC;
      adr_reg      <= RESET_PC;
      halted_reg   <= 1'b0;
      stale_reg    <= 1'b0;
      count_reg    <= '0;
    end else begin
      state_reg    <= state_next;
      fetch_pc_reg <= fetch_pc_next;
      adr_reg      <= adr_next;
      halted_reg   <= halted_next;
      stale_reg    <= stale_next;
      count_reg    <= count_next;
    end
  end

  // Shift-register buffer: entry 0 is always the head, so the outputs come
  // straight from registers. A pop shifts down; a push lands just above the
  // surviving entries.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
    entry_t shifted;
    entry_t entry_next;

    if (gi < DEPTH - 1) begin : g_shift
      assign shifted = entry_reg[gi+1];
    end else begin : g_last
      assign shifted = entry_reg[gi];
    end

    // Select new contents of this slot
    always_comb begin
      entry_next = entry_reg[gi];
      if (push && wr_idx == CW'(gi)) entry_next = push_entry;
      else if (pop)                  entry_next = shifted;
    end

    // Slot storage
    always_ff @(posedge clk_i) begin
      if (!rst_i) entry_reg[gi] <= '0;
      else        entry_reg[gi] <= entry_next;
    end
  end

  assign ifu_stb_o = (state_reg == S_REQ);
  assign ifu_cyc_o = ifu_stb_o;
  assign ifu_adr_o = adr_reg;
  assign ifu_dat_o = '0;
  assign ifu_we_o  = 1'b0;

  assign valid_o = (count_reg != '0);
  assign instr_o = entry_reg[0].instr;
  assign pc_o    = entry_reg[0].pc;
  assign fault_o = entry_reg[0].fault;

endmodule

// File: tb/tb_ifetch.sv
// tb_ifetch: self-checking bench for ifetch with a boot-ROM Wishbone slave
// model and a stream-level reference model of the delivered instructions.
module tb_ifetch;

  typedef struct packed {
    logic        f;
    logic [15:0] pc;
    logic [63:0] ins;
  } del_t;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b0;
  logic [15:0] ifu_adr_o;
  logic [63:0] ifu_dat_i = '0;
  logic [63:0] ifu_dat_o;
  logic        ifu_we_o, ifu_cyc_o, ifu_stb_o;
  logic        ifu_ack_i = 1'b0;
  logic        ifu_err_i = 1'b0;
  logic        redirect_i = 1'b0;
  logic [15:0] redirect_pc_i = '0;
  logic        valid_o;
  logic        ready_i = 1'b0;
  logic [63:0] instr_o;
  logic [15:0] pc_o;
  logic        fault_o;

  int checks = 0;
  int errors = 0;

  // slave model controls
  int          slave_lat = 0;
  bit          slave_mute = 0;
  bit          err_en = 0;
  logic [15:0] err_addr = 16'h0000;
  bit          force_ack = 0;
  int          wait_cnt = 0;
  bit          acked = 0;
  bit          stb_prev = 0;
  int          gap_viol = 0;

  logic [15:0] strobe_q [$];
  del_t        deliv_q  [$];

  ifetch #(
    .ADR_WIDTH(16), .DAT_WIDTH(64), .RESET_PC(16'h0000), .DEPTH(2), .TIMEOUT(4)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .ifu_adr_o(ifu_adr_o), .ifu_dat_i(ifu_dat_i), .ifu_dat_o(ifu_dat_o),
    .ifu_we_o(ifu_we_o), .ifu_cyc_o(ifu_cyc_o), .ifu_stb_o(ifu_stb_o),
    .ifu_ack_i(ifu_ack_i), .ifu_err_i(ifu_err_i),
    .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i),
    .valid_o(valid_o), .ready_i(ready_i),
    .instr_o(instr_o), .pc_o(pc_o), .fault_o(fault_o)
  );

  always #5 clk_i = ~clk_i;

  function automatic logic [63:0] rom(input logic [15:0] a);
    case (a)
      16'h0000: return 64'h00000000deadbabe;
      16'h0008: return 64'h0286c01002000010;
      16'h0010: return 64'h02804000000002a0;
      16'h0048: return 64'h0407360000000000;
      default:  return {16'hc0de, a, ~a, a ^ 16'h5a5a};
    endcase
  endfunction

  // Monitor (strobe starts, gaps, deliveries) and ROM slave, on the falling edge
  always @(negedge clk_i) begin
    if (rst_i) begin
      if (ifu_stb_o && !stb_prev) strobe_q.push_back(ifu_adr_o);
      if (acked && ifu_stb_o) gap_viol++;
      if (valid_o && ready_i && !redirect_i) deliv_q.push_back('{fault_o, pc_o, instr_o});
    end
    stb_prev  = ifu_stb_o;
    acked     = 0;
    ifu_ack_i = 0;
    ifu_err_i = 0;
    ifu_dat_i = '0;
    if (force_ack) begin
      ifu_ack_i = 1;
      ifu_dat_i = 64'h0000000000000bad;
    end else if (ifu_stb_o && !slave_mute) begin
      if (wait_cnt >= slave_lat) begin
        if (err_en && ifu_adr_o == err_addr) ifu_err_i = 1;
        else begin
          ifu_ack_i = 1;
          ifu_dat_i = rom(ifu_adr_o);
        end
        acked    = 1;
        wait_cnt = 0;
      end else wait_cnt++;
    end else wait_cnt = 0;
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic apply_reset();
    rst_i = 0; ready_i = 0; redirect_i = 0; redirect_pc_i = '0;
    slave_lat = 0; slave_mute = 0; err_en = 0; force_ack = 0;
    repeat (3) tick();
    strobe_q.delete();
    deliv_q.delete();
    gap_viol = 0;
    rst_i = 1;
  endtask

  task automatic test_reset();
    rst_i = 0;
    repeat (2) tick();
    checks++;
    if (ifu_stb_o !== 1'b0 || ifu_cyc_o !== 1'b0)
      begin errors++; $display("FAIL rst_stb: got stb=%b cyc=%b expected 0 0", ifu_stb_o, ifu_cyc_o); end
    checks++;
    if (ifu_adr_o !== 16'h0000)
      begin errors++; $display("FAIL rst_adr: got %h expected 0000", ifu_adr_o); end
    checks++;
    if (valid_o !== 1'b0 || fault_o !== 1'b0)
      begin errors++; $display("FAIL rst_valid: got valid=%b fault=%b expected 0 0", valid_o, fault_o); end
    checks++;
    if (instr_o !== 64'h0 || pc_o !== 16'h0)
      begin errors++; $display("FAIL rst_head: got instr=%h pc=%h expected 0 0", instr_o, pc_o); end
    checks++;
    if (ifu_we_o !== 1'b0 || ifu_dat_o !== 64'h0)
      begin errors++; $display("FAIL rst_tie: got we=%b dat=%h expected 0 0", ifu_we_o, ifu_dat_o); end
    rst_i = 1;
    tick();
    checks++;
    if (ifu_stb_o !== 1'b1 || ifu_adr_o !== 16'h0000)
      begin errors++; $display("FAIL first_stb: got stb=%b adr=%h expected 1 0000", ifu_stb_o, ifu_adr_o); end
  endtask

  task automatic test_sequential();
    logic [15:0] epc [3];
    logic [63:0] eins [3];
    int i;
    epc[0] = 16'h0000; eins[0] = 64'h00000000deadbabe;
    epc[1] = 16'h0008; eins[1] = 64'h0286c01002000010;
    epc[2] = 16'h0010; eins[2] = 64'h02804000000002a0;
    apply_reset();
    ready_i = 1;
    tick();
    tick();
    checks++;
    if (valid_o !== 1'b1 || pc_o !== 16'h0000)
      begin errors++; $display("FAIL ack_latency: got valid=%b pc=%h expected 1 0000", valid_o, pc_o); end
    for (i = 0; i < 60 && deliv_q.size() < 3; i++) tick();
    checks++;
    if (deliv_q.size() < 3)
      begin errors++; $display("FAIL seq_count: got %0d deliveries expected 3", deliv_q.size()); end
    else begin
      for (int k = 0; k < 3; k++) begin
        checks++;
        if (deliv_q[k].pc !== epc[k] || deliv_q[k].ins !== eins[k] || deliv_q[k].f !== 1'b0)
          begin errors++; $display("FAIL seq_word%0d: got pc=%h instr=%h f=%b expected pc=%h instr=%h f=0",
                                   k, deliv_q[k].pc, deliv_q[k].ins, deliv_q[k].f, epc[k], eins[k]); end
      end
    end
    checks++;
    if (gap_viol != 0)
      begin errors++; $display("FAIL seq_gap: got %0d strobes without idle cycle expected 0", gap_viol); end
  endtask

  task automatic test_backpressure();
    int i;
    apply_reset();
    repeat (30) tick();
    checks++;
    if (valid_o !== 1'b1 || pc_o !== 16'h0000 || instr_o !== 64'h00000000deadbabe)
      begin errors++; $display("FAIL bp_head: got valid=%b pc=%h instr=%h expected 1 0000 00000000deadbabe", valid_o, pc_o, instr_o); end
    checks++;
    if (strobe_q.size() != 2 || ifu_stb_o !== 1'b0)
      begin errors++; $display("FAIL bp_strobes: got %0d strobes stb=%b expected 2 0", strobe_q.size(), ifu_stb_o); end
    ready_i = 1;
    for (i = 0; i < 40 && (strobe_q.size() < 3 || deliv_q.size() < 3); i++) tick();
    checks++;
    if (strobe_q.size() < 3 || deliv_q.size() < 3)
      begin errors++; $display("FAIL bp_resume: got %0d strobes %0d deliveries expected 3 3", strobe_q.size(), deliv_q.size()); end
    else begin
      checks++;
      if (strobe_q[2] !== 16'h0010)
        begin errors++; $display("FAIL bp_resume_adr: got %h expected 0010", strobe_q[2]); end
      checks++;
      if (deliv_q[0].pc !== 16'h0000 || deliv_q[1].pc !== 16'h0008 || deliv_q[2].pc !== 16'h0010)
        begin errors++; $display("FAIL bp_order: got %h %h %h expected 0000 0008 0010", deliv_q[0].pc, deliv_q[1].pc, deliv_q[2].pc); end
    end
  endtask

  task automatic test_redirect_mid_req();
    int i;
    apply_reset();
    ready_i = 1;
    slave_lat = 3;
    for (i = 0; i < 80 && !(ifu_stb_o && ifu_adr_o == 16'h0010); i++) tick();
    checks++;
    if (!(ifu_stb_o && ifu_adr_o == 16'h0010))
      begin errors++; $display("FAIL redir_wait: got no strobe at 0010 expected one"); end
    else begin
      redirect_i = 1; redirect_pc_i = 16'h0048;
      tick();
      redirect_i = 0;
      checks++;
      if (ifu_stb_o !== 1'b1 || ifu_adr_o !== 16'h0010)
        begin errors++; $display("FAIL redir_hold: got stb=%b adr=%h expected 1 0010", ifu_stb_o, ifu_adr_o); end
      for (i = 0; i < 60 && deliv_q.size() < 3; i++) tick();
      checks++;
      if (deliv_q.size() < 3)
        begin errors++; $display("FAIL redir_count: got %0d deliveries expected 3", deliv_q.size()); end
      else begin
        checks++;
        if (deliv_q[2].pc !== 16'h0048 || deliv_q[2].ins !== 64'h0407360000000000)
          begin errors++; $display("FAIL redir_word: got pc=%h instr=%h expected 0048 0407360000000000", deliv_q[2].pc, deliv_q[2].ins); end
        checks++;
        if (strobe_q.size() < 4 || strobe_q[3] !== 16'h0048)
          begin errors++; $display("FAIL redir_adr: got %0d strobes, 4th=%h expected 0048", strobe_q.size(),
                                   (strobe_q.size() >= 4) ? strobe_q[3] : 16'hxxxx); end
      end
    end
  endtask

  task automatic test_error();
    int i;
    apply_reset();
    ready_i = 1; err_en = 1; err_addr = 16'h0020;
    for (i = 0; i < 80 && deliv_q.size() < 5; i++) tick();
    checks++;
    if (deliv_q.size() < 5)
      begin errors++; $display("FAIL err_count: got %0d deliveries expected 5", deliv_q.size()); end
    else begin
      checks++;
      if (deliv_q[3].f !== 1'b0 || deliv_q[3].pc !== 16'h0018)
        begin errors++; $display("FAIL err_pre: got pc=%h f=%b expected 0018 0", deliv_q[3].pc, deliv_q[3].f); end
      checks++;
      if (deliv_q[4].f !== 1'b1 || deliv_q[4].pc !== 16'h0020 || deliv_q[4].ins !== 64'h0)
        begin errors++; $display("FAIL err_entry: got f=%b pc=%h instr=%h expected 1 0020 0", deliv_q[4].f, deliv_q[4].pc, deliv_q[4].ins); end
    end
    repeat (20) tick();
    checks++;
    if (strobe_q.size() != 5 || ifu_stb_o !== 1'b0 || deliv_q.size() != 5)
      begin errors++; $display("FAIL err_halt: got %0d strobes %0d deliveries stb=%b expected 5 5 0", strobe_q.size(), deliv_q.size(), ifu_stb_o); end
    redirect_i = 1; redirect_pc_i = 16'h0000;
    tick();
    redirect_i = 0;
    for (i = 0; i < 40 && deliv_q.size() < 6; i++) tick();
    checks++;
    if (deliv_q.size() < 6)
      begin errors++; $display("FAIL err_restart: got %0d deliveries expected 6", deliv_q.size()); end
    else if (deliv_q[5].pc !== 16'h0000 || deliv_q[5].ins !== 64'h00000000deadbabe || deliv_q[5].f !== 1'b0)
      begin errors++; $display("FAIL err_restart: got pc=%h instr=%h f=%b expected 0000 00000000deadbabe 0", deliv_q[5].pc, deliv_q[5].ins, deliv_q[5].f); end
  endtask

  task automatic test_reset_mid();
    int i;
    apply_reset();
    slave_lat = 4;
    for (i = 0; i < 60 && !(valid_o && ifu_stb_o); i++) tick();
    rst_i = 0;
    tick();
    checks++;
    if (ifu_stb_o !== 1'b0 || ifu_cyc_o !== 1'b0 || valid_o !== 1'b0)
      begin errors++; $display("FAIL rstmid_drop: got stb=%b cyc=%b valid=%b expected 0 0 0", ifu_stb_o, ifu_cyc_o, valid_o); end
    tick();
    force_ack = 1; rst_i = 1;
    tick();
    force_ack = 0;
    checks++;
    if (ifu_stb_o !== 1'b1 || ifu_adr_o !== 16'h0000 || valid_o !== 1'b0)
      begin errors++; $display("FAIL rstmid_restart: got stb=%b adr=%h valid=%b expected 1 0000 0", ifu_stb_o, ifu_adr_o, valid_o); end
    deliv_q.delete();
    ready_i = 1;
    for (i = 0; i < 40 && deliv_q.size() < 1; i++) tick();
    checks++;
    if (deliv_q.size() < 1 || deliv_q[0].pc !== 16'h0000 || deliv_q[0].ins !== 64'h00000000deadbabe)
      begin errors++; $display("FAIL rstmid_late_ack: got %0d deliveries first pc=%h instr=%h expected pc=0000 instr=00000000deadbabe",
                               deliv_q.size(), (deliv_q.size() > 0) ? deliv_q[0].pc : 16'hxxxx,
                               (deliv_q.size() > 0) ? deliv_q[0].ins : 64'hx); end
  endtask

`ifdef IFETCH_TIMEOUT_EN
  task automatic test_timeout();
    int hi;
    apply_reset();
    slave_mute = 1;
    tick();
    hi = 0;
    for (int i = 0; i < 40 && ifu_stb_o; i++) begin hi++; tick(); end
    checks++;
    if (hi != 4)
      begin errors++; $display("FAIL to_len: got %0d strobe cycles expected 4", hi); end
    checks++;
    if (valid_o !== 1'b1 || fault_o !== 1'b1 || pc_o !== 16'h0000 || instr_o !== 64'h0)
      begin errors++; $display("FAIL to_entry: got valid=%b fault=%b pc=%h instr=%h expected 1 1 0000 0", valid_o, fault_o, pc_o, instr_o); end
    repeat (10) tick();
    checks++;
    if (strobe_q.size() != 1 || ifu_stb_o !== 1'b0)
      begin errors++; $display("FAIL to_halt: got %0d strobes stb=%b expected 1 0", strobe_q.size(), ifu_stb_o); end
    slave_mute = 0;
  endtask
`endif

  // Random ready, latency and redirects; delivered stream checked against
  // the sequential-PC model (fault at err_addr halts until the next redirect)
  task automatic test_random();
    logic [15:0] exp_pc;
    logic [15:0] tgt;
    bit          halted;
    int          n_del;
    del_t        d;
    apply_reset();
    err_en = 1; err_addr = 16'h0040;
    exp_pc = 16'h0000; halted = 0; n_del = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      tick();
      redirect_i = 0;
      while (deliv_q.size() > 0) begin
        d = deliv_q.pop_front();
        n_del++;
        checks++;
        if (halted) begin
          errors++; $display("FAIL rnd_after_fault: got delivery pc=%h expected none until redirect", d.pc);
        end else if (d.pc !== exp_pc) begin
          errors++; $display("FAIL rnd_pc: got %h expected %h", d.pc, exp_pc);
        end else if (exp_pc == err_addr) begin
          if (d.f !== 1'b1 || d.ins !== 64'h0)
            begin errors++; $display("FAIL rnd_fault: got f=%b instr=%h expected 1 0 at %h", d.f, d.ins, exp_pc); end
          halted = 1;
        end else begin
          if (d.f !== 1'b0 || d.ins !== rom(exp_pc))
            begin errors++; $display("FAIL rnd_word: got f=%b instr=%h expected 0 %h at %h", d.f, d.ins, rom(exp_pc), exp_pc); end
          exp_pc = exp_pc + 16'h0008;
        end
      end
      ready_i   = ($urandom_range(0, 3) != 0);
      slave_lat = $urandom_range(0, 3);
      if ($urandom_range(0, 29) == 0) begin
        case ($urandom_range(0, 3))
          0:       tgt = 16'hffe0 | 16'($urandom_range(0, 31));
          1:       tgt = 16'h0030 | 16'($urandom_range(0, 7));
          default: tgt = 16'($urandom_range(0, 255));
        endcase
        redirect_i = 1; redirect_pc_i = tgt;
        exp_pc = tgt & 16'hfff8;
        halted = 0;
      end
    end
    redirect_i = 0;
    checks++;
    if (n_del < 50)
      begin errors++; $display("FAIL rnd_volume: got %0d deliveries expected at least 50", n_del); end
    checks++;
    if (gap_viol != 0)
      begin errors++; $display("FAIL rnd_gap: got %0d strobes without idle cycle expected 0", gap_viol); end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_backpressure();
    test_redirect_mid_req();
    test_error();
    test_reset_mid();
`ifdef IFETCH_TIMEOUT_EN
    test_timeout();
`endif
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ifetch.md
# ifetch

Instruction fetch unit for the core's front end. It acts as a Wishbone master that issues sequential 64-bit instruction reads to the boot ROM slave, and buffers the returned words in a small FIFO tagged with their PC. It presents those words to the decode stage through a valid/ready handshake. Redirects from execute (jumps, calls) flush the buffer and restart fetching at the new PC.

## Interface
- `ADR_WIDTH`, default 16: byte-address width of the PC and of `ifu_adr_o`.
- `DAT_WIDTH`, default 64: instruction width in bits. Each instruction occupies 8 bytes.
- `RESET_PC`, default 16'h0000: first fetch address after reset.
- `DEPTH`, default 2: instruction buffer entries. Must be a power of two and at least 2.
- `TIMEOUT`, default 255: bus watchdog limit in cycles. Used only with `IFETCH_TIMEOUT_EN`.

- `clk_i`, input, 1: single clock. All logic is on the rising edge.
- `rst_i`, input, 1: synchronous, active-low reset.
- `ifu_adr_o`, output, ADR_WIDTH: Wishbone byte address. Always 8-byte aligned.
- `ifu_dat_i`, input, DAT_WIDTH: Wishbone read data.
- `ifu_dat_o`, output, DAT_WIDTH: tied to 0.
- `ifu_we_o`, output, 1: tied to 0.
- `ifu_cyc_o`, output, 1: Wishbone cycle. Equal to `ifu_stb_o`.
- `ifu_stb_o`, output, 1: Wishbone strobe.
- `ifu_ack_i`, input, 1: Wishbone acknowledge.
- `ifu_err_i`, input, 1: Wishbone error.
- `redirect_i`, input, 1: flush the buffer and restart fetching at `redirect_pc_i`.
- `redirect_pc_i`, input, ADR_WIDTH: new PC. Bits [2:0] are ignored and treated as 0.
- `valid_o`, output, 1: the buffer head holds an entry.
- `ready_i`, input, 1: decode accepts the head this cycle.
- `instr_o`, output, DAT_WIDTH: instruction at the buffer head.
- `pc_o`, output, ADR_WIDTH: address of `instr_o`.
- `fault_o`, output, 1: the head entry came from a bus error or timeout. `instr_o` is 0 for such entries.

## Operation
- The block has three bus states: IDLE, REQ and GAP.
- IDLE -> REQ when `(count + inflight) < DEPTH` and the unit is not halted. On this transition the block drives `ifu_adr_o` = fetch PC.
- REQ holds `stb`/`cyc` high until `ack_i` or `err_i` is seen.
  - On `ack`: push {data, PC, fault=0}, advance the fetch PC by 8, then go to GAP.
  - On `err`: push {0, PC, fault=1}, set `halted`, then go to GAP.
  - If both `ack` and `err` are high, `err` wins.
- GAP drives strobe low for exactly one cycle, then goes to IDLE. The slave needs one idle strobe cycle to finish its bus phase. Because of GAP, back-to-back fetches take 3 cycles each at minimum.
- A redirect while in REQ does not drop strobe. The bus cycle completes normally, but the block marks it stale. The stale response is discarded and is not pushed. The fetch PC is set to `redirect_pc_i & ~7`.
- A redirect in any state:
  - empties the buffer,
  - clears `halted`,
  - loads the fetch PC.
- The fetch PC wraps modulo 2^ADR_WIDTH with no special handling.
- While `halted` is set, no new fetches are issued. The fault entry is still delivered normally.
- Buffer pop happens on `valid_o && ready_i`. A push and a pop in the same cycle are both performed and the count is unchanged.

## Timing
- Reset values:
  - `ifu_stb_o` = `ifu_cyc_o` = 0, `ifu_adr_o` = `RESET_PC`
  - `valid_o` = 0, `instr_o` = 0, `pc_o` = 0, `fault_o` = 0
  - state = IDLE, buffer empty, not halted, no stale flag
- The first strobe is asserted on the first cycle after `rst_i` is released.
- Reset asserted during REQ drops strobe at that clock edge. Any late `ack` arriving afterwards is ignored.
- Latency from `ack` to `valid_o` is 1 cycle, because the push is registered. `instr_o`, `pc_o` and `fault_o` are registered buffer outputs.
- Redirect and `ready_i` in the same cycle: redirect wins, the pop is ignored, and `valid_o` = 0 on the next cycle.
- Redirect and `ack` in the same cycle: the data is discarded. The next strobe is at `redirect_pc_i` after GAP.
- When the buffer is full, the block stays in IDLE. Fetching resumes on the cycle after a pop frees a slot.

## Configuration
- `IFETCH_TIMEOUT_EN` defined:
  - An 8-bit minimum counter runs while in REQ.
  - When the counter reaches `TIMEOUT` with no `ack`/`err`, strobe is dropped and a fault entry is pushed, exactly as for `err`.
  - The block then goes to GAP and sets `halted`.
- `IFETCH_TIMEOUT_EN` undefined:
  - No counter is built, and REQ waits indefinitely.

## Test plan
- Sequential fetch from a ROM model, with `ready_i` = 1:
  - Release reset. The bench must see:
    - `pc_o` = 0, `instr_o` = 64'h00000000deadbabe
    - `pc_o` = 8, `instr_o` = 64'h0286c01002000010
    - `pc_o` = 0x10, `instr_o` = 64'h02804000000002a0
  - Strobes must be separated by at least one low cycle.
- Backpressure: hold `ready_i` = 0. `valid_o` stays 1 with PC 0. Exactly 2 strobes are issued, then none. Raise `ready_i`; fetching resumes at PC 0x10.
- Redirect mid-REQ: assert `redirect_i` with `redirect_pc_i` = 0x48 while the fetch at 0x10 is pending. The 0x10 data is never delivered. The next entry is `pc_o` = 0x48, `instr_o` = 64'h0407360000000000.
- Error: the model returns `err` at 0x20. The bench sees `fault_o` = 1, `pc_o` = 0x20, `instr_o` = 0, and no further strobe. A redirect to 0 restarts fetching with 64'h00000000deadbabe.
- Reset mid-transaction: pull `rst_i` low during REQ. On the next cycle, strobe = 0 and `valid_o` = 0. After release, the first `ifu_adr_o` = 0.
- With `IFETCH_TIMEOUT_EN` and `TIMEOUT` = 4, the model never acks. Strobe drops after 4 cycles in REQ, and a fault entry with `pc_o` = 0 is delivered.
